mem_access_unit: RTL

- Consumer end of the EX/MEM pipeline register. Takes the registered ALU result as the address, plus the store data and memory control.
- Runs one data-memory transaction per load/store over a req/ack bus.
- Stalls the pipeline while the bus is busy.
- Delivers byte-lane-extracted, sign- or zero-extended load data to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one req/ack bus transaction per load/store, with byte lanes and load extension.
// Optional ack watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] w_data_in,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  load_valid_out,
  output logic                  misalign_out,
  output logic                  bus_req_out,
  output logic                  bus_we_out,
  output logic [ADDR_WIDTH-1:0] bus_addr_out,
  output logic [3:0]            bus_be_out,
  output logic [DATA_WIDTH-1:0] bus_wdata_out,
  input  logic                  bus_ack_in,
  input  logic [DATA_WIDTH-1:0] bus_rdata_in
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic                    bus_we_q;
  logic [3:0]              bus_be_q, be_in;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, wdata_in;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic                    is_load_q;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d, rdata_ext;
  logic                    load_valid_q, load_valid_d;
  logic                    err_q, err_d;
  logic                    access, is_load_in, misalign_in;
  logic                    stall, mis_comb, latch_en;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;

  assign access      = ex_valid_in && (mem_read_in || mem_write_in);
  assign is_load_in  = mem_read_in && !mem_write_in;
  // funct3[1:0]: 00 byte, 01 half, anything else treated as word
  assign misalign_in = (funct3_in[1:0] == 2'b01 && addr_in[0]) ||
                       (funct3_in[1]   == 1'b1  && addr_in[1:0] != 2'b00);

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = w_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_in    = 4'b0001 << addr_in[1:0];
        wdata_in = {4{w_data_in[7:0]}};
      end
      2'b01: begin
        be_in    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{w_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_byte = bus_rdata_in[8*off_q +: 8];
  assign rd_half = off_q[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  rdata_ext = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      3'b100:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
      3'b001:  rdata_ext = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      3'b101:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      default: rdata_ext = bus_rdata_in;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (latch_en)             cnt_q <= '0;
    else if (state_q == ST_WAIT)   cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mis_comb     = 1'b0;
    latch_en     = 1'b0;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (misalign_in) begin
            mis_comb = 1'b1;
            if (is_load_in) begin
              load_data_d  = '0;
              load_valid_d = 1'b1;
            end
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (bus_ack_in) begin
          state_d = ST_DONE;
          if (is_load_q) begin
            load_data_d  = rdata_ext;
            load_valid_d = 1'b1;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          state_d      = ST_DONE;
          err_d        = 1'b1;
          load_data_d  = '0;
          load_valid_d = is_load_q;
        end
`endif
      end
      // DONE: inputs still show the completed access, so they are ignored
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bus_addr_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      is_load_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
      if (latch_en) begin
        bus_addr_q  <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
        bus_we_q    <= mem_write_in;
        bus_be_q    <= be_in;
        bus_wdata_q <= wdata_in;
        funct3_q    <= funct3_in;
        off_q       <= addr_in[1:0];
        is_load_q   <= is_load_in;
      end
    end
  end

  // Combinational outputs are gated by rst so reset forces them low immediately
  assign stall_out      = stall && !rst;
  assign misalign_out   = (mis_comb && !rst) || err_q;
  assign bus_req_out    = (state_q == ST_WAIT);
  assign bus_we_out     = bus_we_q;
  assign bus_addr_out   = bus_addr_q;
  assign bus_be_out     = bus_be_q;
  assign bus_wdata_out  = bus_wdata_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;

endmodule
